// File: rtl/macc_pipe.sv
// Pipelined multiply-accumulate block: registered operands, optional product pipeline,
// and a wrapping accumulator with a sticky overflow flag behind a valid/ready handshake.
module macc_pipe #(
  parameter bit A_SIGNED   = 1'b0,
  parameter bit B_SIGNED   = 1'b0,
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 8,
  parameter int Y_WIDTH    = 24,
  parameter int MUL_STAGES = 1
) (
  input  logic               CLK,
  input  logic               ARST_N,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic               ACC_LOAD,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [Y_WIDTH-1:0] Y,
  output logic               OVF
);

  localparam int P_W      = A_WIDTH + B_WIDTH;
  localparam bit SWAP     = (A_WIDTH > B_WIDTH);
  localparam int S_W      = SWAP ? B_WIDTH : A_WIDTH;
  localparam int L_W      = SWAP ? A_WIDTH : B_WIDTH;
  localparam bit S_SIGNED = SWAP ? B_SIGNED : A_SIGNED;
  localparam bit L_SIGNED = SWAP ? A_SIGNED : B_SIGNED;
  localparam bit P_SIGNED = S_SIGNED && L_SIGNED;
  localparam int ST_W     = P_W + 2;

  logic               w_stall;
  logic               r_s0Valid;
  logic               r_s0Load;
  logic [A_WIDTH-1:0] r_a;
  logic [B_WIDTH-1:0] r_b;
  logic [S_W-1:0]     w_short;
  logic [L_W-1:0]     w_long;
  logic [P_W-1:0]     w_shortExt;
  logic [P_W-1:0]     w_longExt;
  logic [P_W-1:0]     w_prod;
  logic [ST_W-1:0]    w_s0Stage;
  logic [ST_W-1:0]    w_accStage;
  logic               w_accValid;
  logic               w_accLoad;
  logic [P_W-1:0]     w_accProd;
  logic [Y_WIDTH-1:0] w_pExt;
  logic               w_truncOvf;
  logic [Y_WIDTH:0]   w_sum;
  logic               w_addOvf;
  logic               r_outValid;
  logic               r_ovf;
  logic [Y_WIDTH-1:0] r_acc;

  // A result that downstream has not taken freezes the whole pipe.
  assign w_stall  = r_outValid && !OUT_READY;
  assign IN_READY = !w_stall;

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_s0Valid <= 1'b0;
      r_s0Load  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
    end else if (!w_stall) begin
      r_s0Valid <= IN_VALID;
      r_s0Load  <= ACC_LOAD;
      r_a       <= A;
      r_b       <= B;
    end
  end

  generate
    if (SWAP) begin : gSwap
      assign w_short = r_b;
      assign w_long  = r_a;
    end else begin : gNoSwap
      assign w_short = r_a;
      assign w_long  = r_b;
    end
  endgenerate

  // Extending both lanes to P_W makes the low P_W product bits exact for either signedness.
  assign w_shortExt = {{L_W{P_SIGNED & w_short[S_W-1]}}, w_short};
  assign w_longExt  = {{S_W{P_SIGNED & w_long[L_W-1]}}, w_long};
  assign w_prod     = w_shortExt * w_longExt;
  assign w_s0Stage  = {r_s0Valid, r_s0Load, w_prod};

  generate
    if (MUL_STAGES == 0) begin : gNoPipe
      assign w_accStage = w_s0Stage;
    end else begin : gPipe
      logic [MUL_STAGES-1:0][ST_W-1:0] r_pipe;
      always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
          r_pipe <= '0;
        end else if (!w_stall) begin
          r_pipe[0] <= w_s0Stage;
          for (int i = 1; i < MUL_STAGES; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end
      assign w_accStage = r_pipe[MUL_STAGES-1];
    end
  endgenerate

  assign w_accValid = w_accStage[ST_W-1];
  assign w_accLoad  = w_accStage[ST_W-2];
  assign w_accProd  = w_accStage[P_W-1:0];

  generate
    if (Y_WIDTH > P_W) begin : gExtend
      assign w_pExt     = {{(Y_WIDTH-P_W){P_SIGNED & w_accProd[P_W-1]}}, w_accProd};
      assign w_truncOvf = 1'b0;
    end else if (Y_WIDTH == P_W) begin : gExact
      assign w_pExt     = w_accProd;
      assign w_truncOvf = 1'b0;
    end else begin : gTrunc
      logic [P_W-Y_WIDTH-1:0] w_dropped;
      assign w_dropped  = w_accProd[P_W-1:Y_WIDTH];
      assign w_pExt     = w_accProd[Y_WIDTH-1:0];
      // Signed results only lose information if the dropped bits are not pure sign copies.
      assign w_truncOvf = P_SIGNED ? (w_dropped != {(P_W-Y_WIDTH){w_accProd[Y_WIDTH-1]}})
                                   : (|w_dropped);
    end
  endgenerate

  assign w_sum    = {1'b0, r_acc} + {1'b0, w_pExt};
  assign w_addOvf = P_SIGNED ? ((r_acc[Y_WIDTH-1] == w_pExt[Y_WIDTH-1]) &&
                                (w_sum[Y_WIDTH-1] != r_acc[Y_WIDTH-1]))
                             : w_sum[Y_WIDTH];

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_outValid <= 1'b0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
    end else if (!w_stall) begin
      r_outValid <= w_accValid;
      if (w_accValid) begin
        if (w_accLoad) begin
          r_acc <= w_pExt;
          r_ovf <= w_truncOvf;
        end else begin
          r_acc <= w_sum[Y_WIDTH-1:0];
          r_ovf <= r_ovf | w_addOvf | w_truncOvf;
        end
      end
    end
  end

  assign OUT_VALID = r_outValid;
  assign Y         = r_acc;
  assign OVF       = r_ovf;

endmodule
